// File: rtl/el2_ccm_pkg.sv
// Shared types and helpers for the banked CCM front-end (el2_ccm_bank_ctrl).
package el2_ccm_pkg;

    localparam int unsigned CH_IDX_W   = 3;
    localparam int unsigned BANK_IDX_W = 4;

    typedef logic [CH_IDX_W-1:0]   el2_ccm_ch_idx_t;
    typedef logic [BANK_IDX_W-1:0] el2_ccm_bank_idx_t;

    typedef enum logic {
        EL2_CCM_RD = 1'b0,
        EL2_CCM_WR = 1'b1
    } el2_ccm_op_e;

    typedef struct packed {
        logic              valid;
        el2_ccm_ch_idx_t   ch;
        el2_ccm_bank_idx_t bank;
    } el2_ccm_rsp_t;

    function automatic int unsigned BANK_SEL_W(input int unsigned num_banks);
        return $clog2(num_banks);
    endfunction

endpackage

// File: rtl/el2_ccm_rr_arb.sv
// Round-robin arbiter over NUM_CH requestors; pointer moves past the winner only on a grant.
module el2_ccm_rr_arb
    import el2_ccm_pkg::*;
#(
    parameter int unsigned NUM_CH = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NUM_CH-1:0] i_req,
    output logic [NUM_CH-1:0] o_gnt,
    output el2_ccm_ch_idx_t   o_gnt_idx
);

    el2_ccm_ch_idx_t r_ptr;
    logic            w_any;

    always_comb begin
        int unsigned idx;
        idx       = 0;
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_any     = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = (int'(r_ptr) + i) % NUM_CH;
            if (!w_any && i_req[idx +: 1] == 1'b1) begin
                w_any          = 1'b1;
                o_gnt[idx +: 1] = 1'b1;
                o_gnt_idx      = el2_ccm_ch_idx_t'(idx);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= el2_ccm_ch_idx_t'((int'(o_gnt_idx) + 1) % NUM_CH);
        end
    end

endmodule

// File: rtl/el2_ccm_bank_ctrl.sv
// Multi-channel, word-interleaved banked CCM front-end with per-bank round-robin arbitration.
// Optional background scrubber is built only when EL2_CCM_SCRUB_EN is defined.
module el2_ccm_bank_ctrl
    import el2_ccm_pkg::*;
#(
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned NUM_BANKS      = 4,
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned DATA_W         = 39,
    parameter int unsigned SCRUB_INTERVAL = 256
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic [NUM_CH-1:0]                                      req_valid,
    output logic [NUM_CH-1:0]                                      req_ready,
    input  logic [NUM_CH-1:0]                                      req_we,
    input  logic [NUM_CH*ADDR_W-1:0]                               req_addr,
    input  logic [NUM_CH*DATA_W-1:0]                               req_wdata,
    output logic [NUM_CH-1:0]                                      rsp_valid,
    output logic [NUM_CH*DATA_W-1:0]                               rsp_rdata,
    output logic [NUM_BANKS-1:0]                                   bank_en,
    output logic [NUM_BANKS-1:0]                                   bank_we,
    output logic [NUM_BANKS*(ADDR_W-BANK_SEL_W(NUM_BANKS))-1:0]    bank_addr,
    output logic [NUM_BANKS*DATA_W-1:0]                            bank_wdata,
    input  logic [NUM_BANKS*DATA_W-1:0]                            bank_rdata,
    output logic                                                   scrub_valid,
    output logic [ADDR_W-1:0]                                      scrub_addr,
    output logic [DATA_W-1:0]                                      scrub_rdata
);

    localparam int unsigned BSW   = BANK_SEL_W(NUM_BANKS);
    localparam int unsigned ROW_W = ADDR_W - BSW;

    if (NUM_CH < 1 || NUM_CH > 8 || NUM_BANKS < 2 || NUM_BANKS > 16 ||
        (NUM_BANKS & (NUM_BANKS - 1)) != 0 || ADDR_W <= BSW || SCRUB_INTERVAL < 1) begin : g_bad_cfg
        $error("el2_ccm_bank_ctrl: illegal parameter set");
    end

    logic [NUM_CH-1:0][BSW-1:0]       w_ch_bank;
    logic [NUM_BANKS-1:0][NUM_CH-1:0] w_bank_req;
    logic [NUM_BANKS-1:0][NUM_CH-1:0] w_bank_gnt;
    el2_ccm_ch_idx_t                  w_gnt_idx [NUM_BANKS];
    el2_ccm_rsp_t                     r_rsp [NUM_CH];

    always_comb begin
        w_ch_bank  = '0;
        w_bank_req = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            w_ch_bank[c] = req_addr[c*ADDR_W +: BSW];
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                w_bank_req[b][c] = req_valid[c] && (req_addr[c*ADDR_W +: BSW] == BSW'(b));
            end
        end
    end

    for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_arb
        el2_ccm_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
            .i_clk     (clk),
            .i_rst     (rst),
            .i_req     (w_bank_req[gb]),
            .o_gnt     (w_bank_gnt[gb]),
            .o_gnt_idx (w_gnt_idx[gb])
        );
    end

    always_comb begin
        req_ready = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            req_ready = req_ready | w_bank_gnt[b];
        end
        if (rst) req_ready = '0;
    end

`ifdef EL2_CCM_SCRUB_EN
    logic [31:0]       r_scrub_cnt;
    logic              r_scrub_pend;
    logic [ADDR_W-1:0] r_scrub_ptr;
    logic              r_scrub_valid;
    logic [ADDR_W-1:0] r_scrub_addr;
    logic [BSW-1:0]    r_scrub_bank;
    logic [BSW-1:0]    w_scrub_bank;
    logic              w_scrub_issue;

    // Scrub only takes a bank that no channel wants this cycle, so it never costs a grant.
    assign w_scrub_bank  = r_scrub_ptr[BSW-1:0];
    assign w_scrub_issue = r_scrub_pend && !(|w_bank_req[w_scrub_bank]) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scrub_cnt   <= '0;
            r_scrub_pend  <= 1'b0;
            r_scrub_ptr   <= '0;
            r_scrub_valid <= 1'b0;
            r_scrub_addr  <= '0;
            r_scrub_bank  <= '0;
        end else begin
            r_scrub_valid <= w_scrub_issue;
            if (w_scrub_issue) begin
                r_scrub_pend <= 1'b0;
                r_scrub_cnt  <= '0;
                r_scrub_ptr  <= r_scrub_ptr + 1'b1;
                r_scrub_addr <= r_scrub_ptr;
                r_scrub_bank <= w_scrub_bank;
            end else if (!r_scrub_pend) begin
                if (r_scrub_cnt == 32'(SCRUB_INTERVAL - 1)) begin
                    r_scrub_pend <= 1'b1;
                    r_scrub_cnt  <= '0;
                end else begin
                    r_scrub_cnt <= r_scrub_cnt + 1'b1;
                end
            end
        end
    end

    assign scrub_valid = r_scrub_valid;
    assign scrub_addr  = r_scrub_addr;
    assign scrub_rdata = r_scrub_valid ? bank_rdata[int'(r_scrub_bank)*DATA_W +: DATA_W] : '0;
`else
    assign scrub_valid = 1'b0;
    assign scrub_addr  = '0;
    assign scrub_rdata = '0;
`endif

    always_comb begin
        int unsigned g;
        g          = 0;
        bank_en    = '0;
        bank_we    = '0;
        bank_addr  = '0;
        bank_wdata = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            g = int'(w_gnt_idx[b]);
            if (|w_bank_gnt[b]) begin
                bank_en[b]                    = 1'b1;
                bank_we[b]                    = req_we[g +: 1] == EL2_CCM_WR;
                bank_addr[b*ROW_W +: ROW_W]   = req_addr[g*ADDR_W + BSW +: ROW_W];
                bank_wdata[b*DATA_W +: DATA_W] = req_wdata[g*DATA_W +: DATA_W];
            end
`ifdef EL2_CCM_SCRUB_EN
            else if (w_scrub_issue && w_scrub_bank == BSW'(b)) begin
                bank_en[b]                  = 1'b1;
                bank_addr[b*ROW_W +: ROW_W] = r_scrub_ptr[ADDR_W-1:BSW];
            end
`endif
        end
        if (rst) begin
            bank_en = '0;
            bank_we = '0;
        end
    end

    // One slot per channel suffices: a channel presents a single address, so at most one accept per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned c = 0; c < NUM_CH; c++) r_rsp[c] <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                r_rsp[c].valid <= req_ready[c] && (req_we[c] == EL2_CCM_RD);
                r_rsp[c].ch    <= el2_ccm_ch_idx_t'(c);
                r_rsp[c].bank  <= el2_ccm_bank_idx_t'(w_ch_bank[c]);
            end
        end
    end

    always_comb begin
        int unsigned ch;
        int unsigned bk;
        ch        = 0;
        bk        = 0;
        rsp_valid = '0;
        rsp_rdata = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (r_rsp[k].valid) begin
                ch = int'(r_rsp[k].ch);
                bk = int'(r_rsp[k].bank);
                rsp_valid[ch +: 1]               = 1'b1;
                rsp_rdata[ch*DATA_W +: DATA_W]   = bank_rdata[bk*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_el2_ccm_bank_ctrl.sv
// Scoreboard bench for el2_ccm_bank_ctrl with a behavioural SRAM model per bank.
// Define EL2_CCM_SCRUB_EN for both files to exercise the scrubber.
module tb_el2_ccm_bank_ctrl;

    localparam int NCH   = 2;
    localparam int NBK   = 4;
    localparam int AW    = 16;
    localparam int DW    = 39;
    localparam int ROW_W = 14;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NCH-1:0]       req_valid, req_ready, req_we, rsp_valid;
    logic [NCH*AW-1:0]    req_addr;
    logic [NCH*DW-1:0]    req_wdata, rsp_rdata;
    logic [NBK-1:0]       bank_en, bank_we;
    logic [NBK*ROW_W-1:0] bank_addr;
    logic [NBK*DW-1:0]    bank_wdata;
    logic [NBK*DW-1:0]    bank_rdata = '0;
    logic                 scrub_valid;
    logic [AW-1:0]        scrub_addr;
    logic [DW-1:0]        scrub_rdata;

    int checks = 0;
    int errors = 0;
    int rsp_cnt [NCH];
    logic [DW-1:0] exp_q [NCH][$];
    bit   [DW-1:0] mem [NBK][1 << ROW_W];

    always #5 clk = ~clk;

    el2_ccm_bank_ctrl #(
        .NUM_CH(NCH), .NUM_BANKS(NBK), .ADDR_W(AW), .DATA_W(DW), .SCRUB_INTERVAL(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr),
        .bank_wdata(bank_wdata), .bank_rdata(bank_rdata),
        .scrub_valid(scrub_valid), .scrub_addr(scrub_addr), .scrub_rdata(scrub_rdata)
    );

    // Single-port synchronous SRAM behaviour: write on the strobe edge, read data one cycle later.
    always @(posedge clk) begin
        for (int b = 0; b < NBK; b++) begin
            if (bank_en[b]) begin
                if (bank_we[b]) mem[b][bank_addr[b*ROW_W +: ROW_W]] <= bank_wdata[b*DW +: DW];
                else            bank_rdata[b*DW +: DW] <= mem[b][bank_addr[b*ROW_W +: ROW_W]];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int c, input logic v, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        req_valid[c]           = v;
        req_we[c]              = we;
        req_addr[c*AW +: AW]   = addr;
        req_wdata[c*DW +: DW]  = wd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: every rsp_valid pulse must match the oldest expectation for that channel.
    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < NCH; c++) begin
                if (rsp_valid[c]) begin
                    rsp_cnt[c]++;
                    checks++;
                    if (exp_q[c].size() == 0) begin
                        errors++;
                        $display("FAIL rsp_unexpected ch%0d: got 0x%0h expected no response", c, rsp_rdata[c*DW +: DW]);
                    end else begin
                        logic [DW-1:0] e;
                        e = exp_q[c].pop_front();
                        if (rsp_rdata[c*DW +: DW] !== e) begin
                            errors++;
                            $display("FAIL rsp_data ch%0d: got 0x%0h expected 0x%0h", c, rsp_rdata[c*DW +: DW], e);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw;
        int   r0, r1;
        rsp_cnt[0] = 0;
        rsp_cnt[1] = 0;
        mem[1][1] = 39'h12345;
        mem[0][0] = 39'h100;
        mem[0][1] = 39'h101;
        mem[3][0] = 39'h333;
        mem[1][0] = 39'h201;

        rst = 1'b1;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        drive(0, 1'b1, 1'b0, 16'h0001, '0);
        drive(1, 1'b1, 1'b1, 16'h0002, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_bank_en", 64'(bank_en), 64'h0);
        chk("rst_bank_we", 64'(bank_we), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'h0);
        chk("rst_scrub", 64'({scrub_valid, scrub_addr, scrub_rdata}), 64'h0);
        req_valid = '0;
        next_cycle();
        rst = 1'b0;

`ifdef EL2_CCM_SCRUB_EN
        // ch0 hammers bank 0, so the pending scrub of address 0 must wait for it to idle.
        drive(0, 1'b1, 1'b0, 16'h0000, '0);
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (scrub_valid) saw = 1'b1;
            chk("scrub_hammer_ready", 64'(req_ready[0]), 64'h1);
            exp_q[0].push_back(39'h100);
            next_cycle();
        end
        req_valid[0] = 1'b0;
        chk("scrub_blocked", 64'(saw), 64'h0);
        saw = 1'b0;
        for (int i = 0; i < 6 && !saw; i++) begin
            @(negedge clk);
            saw = scrub_valid;
        end
        chk("scrub0_valid", 64'(saw), 64'h1);
        chk("scrub0_addr", 64'(scrub_addr), 64'h0);
        chk("scrub0_rdata", 64'(scrub_rdata), 64'h100);
        @(negedge clk);
        saw = 1'b0;
        for (int i = 0; i < 20 && !saw; i++) begin
            @(negedge clk);
            saw = scrub_valid;
        end
        chk("scrub1_valid", 64'(saw), 64'h1);
        chk("scrub1_addr", 64'(scrub_addr), 64'h1);
        chk("scrub1_rdata", 64'(scrub_rdata), 64'h201);
        next_cycle();
`endif

        // Single read: addr 5 -> bank 1, row 1.
        drive(0, 1'b1, 1'b0, 16'h0005, '0);
        @(negedge clk);
        chk("t1_ready", 64'(req_ready), 64'h1);
        chk("t1_bank_en1", 64'(bank_en[1]), 64'h1);
        chk("t1_bank_we", 64'(bank_we), 64'h0);
        chk("t1_bank_addr1", 64'(bank_addr[1*ROW_W +: ROW_W]), 64'h1);
        exp_q[0].push_back(39'h12345);
        next_cycle();
        req_valid = '0;
        next_cycle();

        // Write bank 2 and read bank 3 concurrently.
        drive(0, 1'b1, 1'b1, 16'h0002, 39'h55);
        drive(1, 1'b1, 1'b0, 16'h0003, '0);
        @(negedge clk);
        chk("t3_ready", 64'(req_ready), 64'h3);
        chk("t3_bank_en", 64'(bank_en[3:2]), 64'h3);
        chk("t3_bank_we", 64'(bank_we), 64'h4);
        chk("t3_wdata2", 64'(bank_wdata[2*DW +: DW]), 64'h55);
        exp_q[1].push_back(39'h333);
        next_cycle();
        req_valid = '0;

        // Write then read-after-write from another channel.
        drive(0, 1'b1, 1'b1, 16'h0008, 39'hAA);
        @(negedge clk);
        chk("t4_wr_ready", 64'(req_ready), 64'h1);
        next_cycle();
        req_valid[0] = 1'b0;
        drive(1, 1'b1, 1'b0, 16'h0008, '0);
        @(negedge clk);
        chk("t4_rd_ready", 64'(req_ready), 64'h2);
        exp_q[1].push_back(39'hAA);
        next_cycle();
        req_valid = '0;
        next_cycle();

        // Reset right after a read is accepted: response discarded, pointers cleared.
        drive(0, 1'b1, 1'b0, 16'h0000, '0);
        @(negedge clk);
        chk("t5_ready", 64'(req_ready), 64'h1);
        next_cycle();
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        chk("t5_rsp_valid_rst", 64'(rsp_valid), 64'h0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rsp_valid_after", 64'(rsp_valid), 64'h0);
        next_cycle();

        // Two channels contend for bank 0: grants alternate starting at ch0.
        r0 = rsp_cnt[0];
        r1 = rsp_cnt[1];
        drive(0, 1'b1, 1'b0, 16'h0000, '0);
        drive(1, 1'b1, 1'b0, 16'h0004, '0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("t2_grant%0d", k), 64'(req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
            if (k % 2 == 0) exp_q[0].push_back(39'h100);
            else            exp_q[1].push_back(39'h101);
            next_cycle();
        end
        req_valid = '0;
        repeat (2) next_cycle();
        chk("t2_rsp_cnt0", 64'(rsp_cnt[0] - r0), 64'h3);
        chk("t2_rsp_cnt1", 64'(rsp_cnt[1] - r1), 64'h3);

        repeat (2) next_cycle();
        chk("sb_drain0", 64'(exp_q[0].size()), 64'h0);
        chk("sb_drain1", 64'(exp_q[1].size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
